cond_logic: RTL and testbench

//   Condition-execution stage directly downstream of the ALU/control decoder.
//   - Holds the architectural NZCV flag register.
//   - Evaluates the instruction's 4-bit condition field against the current flags.
//   - Gates the decoder's pcs/reg_w/mem_w strobes into the processor's write enables.
//   - Updates flags from the ALU under the decoder's 2-bit flag_w control.
//   - Records undefined (cond=1111) instructions in a sticky status bit.

---
 rtl/cond_logic.sv | 108 ++++++++++
 tb/tb_cond_logic.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// cond_logic
//   Condition-execution stage sitting directly after the ALU/control decoder.
//   Holds the architectural NZCV flag register, checks the instruction's
//   condition field against it, and gates the decoder's write strobes. The
//   flags are updated from the ALU under flag_w control, and a sticky status
//   bit records any executed undefined (cond=1111) instruction.
//
// Parameters
//   RESET_FLAGS   NZCV value loaded on reset, order {N,Z,C,V}
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset (dominates en)
//   en            instruction valid/advance; 0 = stall
//   cond          instruction condition field, instr[31:28]
//   alu_flags     ALU result flags {N,Z,C,V}
//   flag_w        [1] write N,Z ; [0] write C,V
//   pcs           decoder PC-write request
//   reg_w         decoder register-write request
//   mem_w         decoder memory-write request
//   no_write      suppress register write (CMP/CMN/TST/TEQ)
//   pc_src        gated PC write
//   reg_write     gated register-file write
//   mem_write     gated data-memory write
//   cond_ex       condition passed for the current instruction
//   flags         registered NZCV {N,Z,C,V}
//   undef         current instruction has cond=1111 (combinational)
//   undef_sticky  set by any executed undef; cleared only by rst
module cond_logic #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       undef,
    output logic       undef_sticky
);

    logic n_f, z_f, c_f, v_f;
    logic pass;
    logic is_undef;

    assign n_f = flags[3];
    assign z_f = flags[2];
    assign c_f = flags[1];
    assign v_f = flags[0];

    // Condition evaluated against the registered flags, i.e. the flags as
    // they stood before this instruction's own update.
    always_comb begin
        pass = 1'b0;
        unique case (cond)
            4'b0000: pass = z_f;
            4'b0001: pass = ~z_f;
            4'b0010: pass = c_f;
            4'b0011: pass = ~c_f;
            4'b0100: pass = n_f;
            4'b0101: pass = ~n_f;
            4'b0110: pass = v_f;
            4'b0111: pass = ~v_f;
            4'b1000: pass = c_f & ~z_f;
            4'b1001: pass = ~c_f | z_f;
            4'b1010: pass = (n_f == v_f);
            4'b1011: pass = (n_f != v_f);
            4'b1100: pass = ~z_f & (n_f == v_f);
            4'b1101: pass = z_f | (n_f != v_f);
            4'b1110: pass = 1'b1;
            4'b1111: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    assign is_undef = (cond == 4'b1111);

    // Reset forces every combinational status/strobe output low.
    assign cond_ex   = pass & ~rst;
    assign undef     = is_undef & ~rst;

    assign pc_src    = en & cond_ex & pcs;
    assign reg_write = en & cond_ex & reg_w & ~no_write;
    assign mem_write = en & cond_ex & mem_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags        <= RESET_FLAGS;
            undef_sticky <= 1'b0;
        end else if (en) begin
            if (cond_ex) begin
                if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
            end
            if (is_undef) undef_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic
//   Scoreboarded bench for cond_logic. Each drive pushes the expected
//   combinational outputs plus the expected post-edge flags/sticky, computed
//   from an independent reference model; each test task pops and compares.
module tb_cond_logic;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic [3:0] flags;
    logic       undef;
    logic       undef_sticky;

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst(rst), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .no_write(no_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .cond_ex(cond_ex), .flags(flags),
        .undef(undef), .undef_sticky(undef_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] outs;   // {pc_src, reg_write, mem_write, cond_ex, undef}
        logic [3:0] fl;     // flags after the edge
        logic       st;     // undef_sticky after the edge
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] mf = 4'b0000;
    logic       ms = 1'b0;

    // Reference condition check: base test from cond[3:1], inverted by cond[0].
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic b;
        case (c[3:1])
            3'd0: b = f[2];
            3'd1: b = f[1];
            3'd2: b = f[3];
            3'd3: b = f[0];
            3'd4: b = f[1] & ~f[2];
            3'd5: b = (f[3] == f[0]);
            3'd6: b = ~f[2] & (f[3] == f[0]);
            default: b = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~b : b;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] c,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic rw, input logic mw,
                         input logic nw);
        exp_t  t;
        logic  ce;
        logic  ud;
        rst = r; en = e; cond = c; alu_flags = af; flag_w = fw;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
        ce = ~r & ref_pass(c, mf);
        ud = ~r & (c == 4'b1111);
        t.outs = {e & ce & p, e & ce & rw & ~nw, e & ce & mw, ce, ud};
        if (r) begin
            mf = 4'b0000;
            ms = 1'b0;
        end else if (e) begin
            if (ce && fw[1]) mf[3:2] = af[3:2];
            if (ce && fw[0]) mf[1:0] = af[1:0];
            if (c == 4'b1111) ms = 1'b1;
        end
        t.fl = mf;
        t.st = ms;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL reset_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got=%b want=00000", i,
                         {flags, undef_sticky});
            end
        end
    endtask

    // Shared per-scenario step body is kept inline in each task below.
    task automatic test_al_then_eq();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            case (i)
                0: drive(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
                default: drive(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0);
            endcase
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL al_eq_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL al_eq_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
        n_checks++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL al_eq_flags got=%b want=0100", flags);
        end
    endtask

    task automatic test_failed_cond();
        @(negedge clk);
        drive(0, 1, 4'b0001, 4'b1111, 2'b11, 1, 1, 1, 0);
        #1;
        x = sb.pop_front();
        n_checks++;
        if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
            n_fail++;
            $display("FAIL ne_outs got=%b want=%b",
                     {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({flags, undef_sticky} !== {x.fl, x.st}) begin
            n_fail++;
            $display("FAIL ne_state got=%b want=%b", {flags, undef_sticky}, {x.fl, x.st});
        end
    endtask

    task automatic test_signed_conds();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: drive(0, 1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0);
                1: drive(0, 1, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0);
                2: drive(0, 1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0);
                3: drive(0, 1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0);
                4: drive(0, 1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0);
                default: drive(0, 1, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0);
            endcase
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL signed_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL signed_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
    endtask

    task automatic test_partial_flag_w();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            case (i)
                0: drive(0, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0);
                1: drive(0, 1, 4'b1110, 4'b1111, 2'b01, 0, 0, 0, 0);
                default: drive(0, 1, 4'b1110, 4'b1100, 2'b10, 0, 0, 0, 0);
            endcase
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL flagw_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL flagw_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
        n_checks++;
        if (flags !== 4'b1111) begin
            n_fail++;
            $display("FAIL flagw_final got=%b want=1111", flags);
        end
    endtask

    task automatic test_undef();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            case (i)
                0: drive(0, 1, 4'b1111, 4'b0101, 2'b11, 1, 1, 1, 0);
                1: drive(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
                2: drive(0, 0, 4'b1111, 4'b0101, 2'b11, 1, 1, 1, 0);
                3: drive(0, 1, 4'b1111, 4'b0101, 2'b11, 1, 1, 1, 0);
                default: drive(1, 1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
            endcase
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL undef_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL undef_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
    endtask

    task automatic test_stall_nowrite();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            case (i)
                0: drive(0, 0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0);
                default: drive(0, 1, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 1);
            endcase
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL stall_outs[%0d] got=%b want=%b", i,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL stall_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] c;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            c = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), c,
                  4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            #1;
            x = sb.pop_front();
            n_checks++;
            if ({pc_src, reg_write, mem_write, cond_ex, undef} !== x.outs) begin
                n_fail++;
                $display("FAIL b2b_outs[%0d] cond=%b got=%b want=%b", i, c,
                         {pc_src, reg_write, mem_write, cond_ex, undef}, x.outs);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({flags, undef_sticky} !== {x.fl, x.st}) begin
                n_fail++;
                $display("FAIL b2b_state[%0d] got=%b want=%b", i,
                         {flags, undef_sticky}, {x.fl, x.st});
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cond = '0; alu_flags = '0; flag_w = '0;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        test_reset();
        test_al_then_eq();
        test_failed_cond();
        test_signed_conds();
        test_partial_flag_w();
        test_undef();
        test_stall_nowrite();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
